// File: rtl/stream_pkg.sv
// Shared types and helpers for the camera-path stream frame packer.
package stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  // Lane counter must be able to represent SCALE itself.
  function automatic int unsigned lane_cnt_w(input int unsigned scale);
    return $clog2(scale + 1);
  endfunction

  // Physical slot of the k-th sample within a packed word.
  function automatic int unsigned lane_pos(input int unsigned lane,
                                           input int unsigned scale,
                                           input bit          lsb_first);
    return lsb_first ? lane : (scale - 1 - lane);
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready holding register for packed words {data, keep, last}.
module stream_out_reg #(
  parameter int unsigned DW = 32,
  parameter int unsigned KW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [KW-1:0] keep_i,
  input  logic          last_i,
  input  logic          m_ready_i,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  output logic [KW-1:0] m_keep_o,
  output logic          m_last_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [KW-1:0] keep_q;
  logic          last_q;

  // Caller only loads when the slot is free, so a held word is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
      last_q  <= last_i;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;
  assign m_last_o  = last_q;

endmodule

// File: rtl/stream_frame_packer.sv
// Frame-aware sample-to-word packer: aligns to SOF, flushes partial words at EOF,
// and captures a programmed number of frames in the camera clock domain.
module stream_frame_packer
  import stream_pkg::*;
#(
  parameter int unsigned DW_IN     = 16,
  parameter int unsigned SCALE     = 2,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned FCW       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW_IN-1:0]       s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic                   s_sof_i,
  input  logic                   s_eof_i,
  output logic [DW_IN*SCALE-1:0] m_data_o,
  output logic [SCALE-1:0]       m_keep_o,
  output logic                   m_last_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [FCW-1:0]         num_frames_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   sof_err_o,
  output logic [FCW-1:0]         frame_cnt_o
);

  localparam int unsigned LW = lane_cnt_w(SCALE);
  localparam int unsigned OW = DW_IN * SCALE;
  localparam int unsigned KW = SCALE;
  localparam logic [LW-1:0] LANE_LAST = LW'(SCALE - 1);

  state_e         state_q, state_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic [OW-1:0]  pdata_q, pdata_d;
  logic [KW-1:0]  pkeep_q, pkeep_d;
  logic [FCW-1:0] fleft_q, fleft_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic           busy_q;

  logic           out_free_c;
  logic           closes_c;
  logic           take_c;
  logic           s_ready_c;
  logic           load_c;
  logic [OW-1:0]  word_data_c;
  logic [KW-1:0]  word_keep_c;
  logic [OW-1:0]  ld_data_c;
  logic [KW-1:0]  ld_keep_c;
  logic           ld_last_c;

  assign out_free_c = !m_valid_o || m_ready_i;
  assign closes_c   = (lane_q == LANE_LAST) || s_eof_i;

  // Pack register with the incoming sample merged into its lane; unused lanes stay zero.
  always_comb begin
    word_data_c = pdata_q | (OW'(s_data_i) <<
                  (lane_pos(32'(lane_q), SCALE, LSB_FIRST != 0) * DW_IN));
    word_keep_c = pkeep_q | (KW'(1) << lane_q);
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    pdata_d   = pdata_q;
    pkeep_d   = pkeep_q;
    fleft_d   = fleft_q;
    fcnt_d    = fcnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    s_ready_c = 1'b0;
    take_c    = 1'b0;
    load_c    = 1'b0;
    ld_data_c = word_data_c;
    ld_keep_c = word_keep_c;
    ld_last_c = s_eof_i;

    unique case (state_q)
      ST_IDLE: begin
        s_ready_c = 1'b1;
        if (start_i) begin
          fleft_d = num_frames_i;
          state_d = ST_WAIT_SOF;
        end
      end
      ST_WAIT_SOF: begin
        // Non-SOF samples are dropped; an SOF that closes a word needs a free slot.
        s_ready_c = (s_sof_i && closes_c) ? out_free_c : 1'b1;
        if (s_valid_i && s_ready_c && s_sof_i) begin
          take_c  = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (s_valid_i && s_sof_i && (lane_q != '0)) begin
          err_d   = 1'b1;
          state_d = ST_FLUSH;
        end else begin
          s_ready_c = closes_c ? out_free_c : 1'b1;
          take_c    = s_valid_i && s_ready_c;
        end
      end
      ST_FLUSH: begin
        if (out_free_c) begin
          load_c    = 1'b1;
          ld_data_c = pdata_q;
          ld_keep_c = pkeep_q;
          ld_last_c = 1'b1;
          lane_d    = '0;
          pdata_d   = '0;
          pkeep_d   = '0;
          state_d   = ST_CAPTURE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_c) begin
      if (closes_c) begin
        load_c  = 1'b1;
        lane_d  = '0;
        pdata_d = '0;
        pkeep_d = '0;
      end else begin
        lane_d  = lane_q + LW'(1);
        pdata_d = word_data_c;
        pkeep_d = word_keep_c;
      end
    end

    // End of frame: count it, then either finish or re-arm for the next SOF.
    if (take_c && s_eof_i) begin
      fcnt_d = fcnt_q + FCW'(1);
      if ((num_frames_i != '0) && (fleft_q == FCW'(1))) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        if (num_frames_i != '0) fleft_d = fleft_q - FCW'(1);
        state_d = ST_WAIT_SOF;
      end
    end

    if (abort_i) begin
      state_d = ST_IDLE;
      lane_d  = '0;
      pdata_d = '0;
      pkeep_d = '0;
      fleft_d = fleft_q;
      fcnt_d  = fcnt_q;
      err_d   = err_q;
      done_d  = 1'b0;
      load_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      pdata_q <= '0;
      pkeep_q <= '0;
      fleft_q <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      pdata_q <= pdata_d;
      pkeep_q <= pkeep_d;
      fleft_q <= fleft_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  stream_out_reg #(
    .DW (OW),
    .KW (KW)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_c),
    .data_i    (ld_data_c),
    .keep_i    (ld_keep_c),
    .last_i    (ld_last_c),
    .m_ready_i (m_ready_i),
    .m_valid_o (m_valid_o),
    .m_data_o  (m_data_o),
    .m_keep_o  (m_keep_o),
    .m_last_o  (m_last_o)
  );

  assign s_ready_o   = s_ready_c;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sof_err_o   = err_q;
  assign frame_cnt_o = fcnt_q;

endmodule
